sdram_init_refresh: RTL and testbench

- Sequencer upstream of the SDRAM command engine, on MEMCLK.
- After reset it runs the JEDEC power-up sequence: wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER. Each command is handed to the engine through a valid/ready handshake.
- Once initialised it raises init_done and schedules periodic refresh. A saturating pending count drives refresh_req/refresh_urgent, and the engine consumes it with refresh_ack between Zorro cycles.

---
 rtl/sdram_init_refresh_pkg.sv | 34 +++
 rtl/sdram_init_refresh_if.sv | 33 +++
 rtl/sdram_init_refresh_scheduler.sv | 72 +++++++
 rtl/sdram_init_refresh.sv | 142 ++++++++++++++
 tb/tb_sdram_init_refresh.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/sdram_init_refresh_pkg.sv
// Shared definitions for the SDRAM init/refresh sequencer: command and state
// encodings, default timing constants and a small helper for sizing counters.
package sdram_init_refresh_pkg;

  typedef enum logic [1:0] {
    CMD_NOP           = 2'd0,
    CMD_PRECHARGE_ALL = 2'd1,
    CMD_AUTO_REFRESH  = 2'd2,
    CMD_LOAD_MODE     = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_PRE     = 3'd1,
    S_REF     = 3'd2,
    S_MODE    = 3'd3,
    S_WAIT    = 3'd4,
    S_RUN     = 3'd5
  } state_e;

  localparam int unsigned DEF_POWERUP_CYCLES   = 10000;
  localparam int unsigned DEF_REFRESH_INTERVAL = 390;
  localparam int unsigned DEF_INIT_REFRESHES   = 8;
  localparam int unsigned DEF_T_RP             = 2;
  localparam int unsigned DEF_T_RFC            = 7;
  localparam int unsigned DEF_T_MRD            = 2;
  localparam logic [11:0] DEF_MODE_WORD        = 12'h020;
  localparam int unsigned DEF_URGENT_THRESH    = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_init_refresh_if.sv
// Handshake/status bundle between the init/refresh sequencer (master) and the
// SDRAM command engine (slave).
//   cmd_valid/cmd/cmd_ready : init command handshake
//   mode_word               : value for MA during LOAD_MODE
//   init_done               : engine owns the SDRAM once high
//   refresh_*               : pending refresh status and engine acknowledge
interface sdram_init_refresh_if;
  import sdram_init_refresh_pkg::*;

  logic        cmd_valid;
  cmd_e        cmd;
  logic        cmd_ready;
  logic [11:0] mode_word;
  logic        init_done;
  logic        refresh_req;
  logic        refresh_urgent;
  logic        refresh_ack;
  logic [2:0]  refresh_pending;
  logic        refresh_overflow;

  modport master (
    output cmd_valid, cmd, mode_word, init_done,
    output refresh_req, refresh_urgent, refresh_pending, refresh_overflow,
    input  cmd_ready, refresh_ack
  );

  modport slave (
    input  cmd_valid, cmd, mode_word, init_done,
    input  refresh_req, refresh_urgent, refresh_pending, refresh_overflow,
    output cmd_ready, refresh_ack
  );

endinterface

// File: rtl/sdram_init_refresh_scheduler.sv
// Periodic refresh scheduler. Generates a tick every REFRESH_INTERVAL cycles
// while enabled and keeps a saturating count of refreshes still owed.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : sequencer has finished init; gates ticks and acks
//   ack       : engine issued one refresh this cycle
//   pending   : owed refresh count (saturates at 7)
//   req       : pending != 0
//   urgent    : pending >= URGENT_THRESH
//   overflow  : sticky, a tick was dropped at saturation
module refresh_scheduler #(
  parameter int unsigned REFRESH_INTERVAL = 390,
  parameter int unsigned URGENT_THRESH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ack,
  output logic [2:0] pending,
  output logic       req,
  output logic       urgent,
  output logic       overflow
);

  localparam int unsigned IntW = $clog2(REFRESH_INTERVAL + 1);

  logic [IntW-1:0] int_q;
  logic [2:0]      pending_q, pending_d;
  logic            ovf_q, ovf_d;
  logic            req_q, urgent_q;
  logic            tick, ack_eff;

  always_comb begin
    tick      = enable && (int_q == IntW'(REFRESH_INTERVAL - 1));
    ack_eff   = enable && ack;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (tick && !ack_eff) begin
      if (pending_q == 3'd7) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + 3'd1;
      end
    end else if (ack_eff && !tick && (pending_q != 3'd0)) begin
      pending_d = pending_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      req_q     <= 1'b0;
      urgent_q  <= 1'b0;
    end else begin
      if (enable) begin
        int_q <= tick ? '0 : int_q + 1'b1;
      end
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      // Flags follow the next-state count so they move with refresh_pending.
      req_q     <= (pending_d != 3'd0);
      urgent_q  <= (32'(pending_d) >= URGENT_THRESH);
    end
  end

  assign pending  = pending_q;
  assign req      = req_q;
  assign urgent   = urgent_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer and refresh scheduler front end. After reset it
// waits POWERUP_CYCLES, then hands PRECHARGE ALL, INIT_REFRESHES x AUTO
// REFRESH and LOAD MODE to the command engine over a valid/ready handshake,
// each followed by its recovery wait, then raises init_done and starts
// periodic refresh scheduling.
//   CLK   : MEMCLK
//   RESET : synchronous active-high reset, restarts the whole sequence
//   bus   : master side of sdram_init_refresh_if
module sdram_init_refresh
  import sdram_init_refresh_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES   = DEF_POWERUP_CYCLES,
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int unsigned INIT_REFRESHES   = DEF_INIT_REFRESHES,
  parameter int unsigned T_RP             = DEF_T_RP,
  parameter int unsigned T_RFC            = DEF_T_RFC,
  parameter int unsigned T_MRD            = DEF_T_MRD,
  parameter logic [11:0] MODE_WORD        = DEF_MODE_WORD,
  parameter int unsigned URGENT_THRESH    = DEF_URGENT_THRESH
) (
  input logic                  CLK,
  input logic                  RESET,
  sdram_init_refresh_if.master bus
);

  // One counter serves both the power-up wait and the post-command waits.
  localparam int unsigned CntMax = max2(max2(POWERUP_CYCLES, T_RP), max2(T_RFC, T_MRD));
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RefW   = $clog2(INIT_REFRESHES + 1);

  state_e          state_q, next_q;
  logic [CntW-1:0] wait_q;
  logic [RefW-1:0] ref_q;
  logic            cmd_valid_q;
  cmd_e            cmd_q;
  logic            init_done_q;
  logic            hs;

  assign hs = cmd_valid_q && bus.cmd_ready;

  // Waits load n-1 on the handshake edge so exactly n idle cycles follow it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_POWERUP;
      next_q      <= S_REF;
      wait_q      <= '0;
      ref_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_POWERUP: begin
          if (wait_q == CntW'(POWERUP_CYCLES - 1)) begin
            wait_q      <= '0;
            state_q     <= S_PRE;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_PRECHARGE_ALL;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_PRE: begin
          if (hs) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            wait_q      <= CntW'(T_RP - 1);
            next_q      <= S_REF;
            state_q     <= S_WAIT;
          end
        end
        S_REF: begin
          if (hs) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            wait_q      <= CntW'(T_RFC - 1);
            ref_q       <= ref_q + 1'b1;
            next_q      <= (ref_q == RefW'(INIT_REFRESHES - 1)) ? S_MODE : S_REF;
            state_q     <= S_WAIT;
          end
        end
        S_MODE: begin
          if (hs) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            wait_q      <= CntW'(T_MRD - 1);
            next_q      <= S_RUN;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            state_q <= next_q;
            unique case (next_q)
              S_REF: begin
                cmd_valid_q <= 1'b1;
                cmd_q       <= CMD_AUTO_REFRESH;
              end
              S_MODE: begin
                cmd_valid_q <= 1'b1;
                cmd_q       <= CMD_LOAD_MODE;
              end
              S_RUN:   init_done_q <= 1'b1;
              default: state_q     <= S_POWERUP;
            endcase
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        S_RUN:   ;
        default: state_q <= S_POWERUP;
      endcase
    end
  end

  logic [2:0] pending;
  logic       req, urgent, overflow;

  refresh_scheduler #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .URGENT_THRESH    (URGENT_THRESH)
  ) u_sched (
    .clk      (CLK),
    .rst      (RESET),
    .enable   (init_done_q),
    .ack      (bus.refresh_ack),
    .pending  (pending),
    .req      (req),
    .urgent   (urgent),
    .overflow (overflow)
  );

  assign bus.cmd_valid        = cmd_valid_q;
  assign bus.cmd              = cmd_q;
  assign bus.mode_word        = MODE_WORD;
  assign bus.init_done        = init_done_q;
  assign bus.refresh_req      = req;
  assign bus.refresh_urgent   = urgent;
  assign bus.refresh_pending  = pending;
  assign bus.refresh_overflow = overflow;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh with POWERUP_CYCLES=16,
// REFRESH_INTERVAL=10, INIT_REFRESHES=2. Cycle c means c rising edges after
// the first edge with RESET low; outputs are sampled 1 ns after each edge.
module tb_sdram_init_refresh;
  import sdram_init_refresh_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always #5 CLK = ~CLK;

  sdram_init_refresh_if bus ();

  sdram_init_refresh #(
    .POWERUP_CYCLES   (16),
    .REFRESH_INTERVAL (10),
    .INIT_REFRESHES   (2),
    .T_RP             (2),
    .T_RFC            (7),
    .T_MRD            (2),
    .MODE_WORD        (12'h020),
    .URGENT_THRESH    (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".cmd_valid"}, bus.cmd_valid, 0);
    check({tag, ".cmd"}, bus.cmd, CMD_NOP);
    check({tag, ".init_done"}, bus.init_done, 0);
    check({tag, ".req"}, bus.refresh_req, 0);
    check({tag, ".urgent"}, bus.refresh_urgent, 0);
    check({tag, ".pending"}, bus.refresh_pending, 0);
    check({tag, ".overflow"}, bus.refresh_overflow, 0);
  endtask

  task automatic check_cmd(input string tag, input logic v, input logic [1:0] c);
    check({tag, ".cmd_valid"}, bus.cmd_valid, v);
    check({tag, ".cmd"}, bus.cmd, c);
  endtask

  task automatic check_ref(input string tag, input int p, input logic rq,
                           input logic ur, input logic ov);
    check({tag, ".pending"}, bus.refresh_pending, p);
    check({tag, ".req"}, bus.refresh_req, rq);
    check({tag, ".urgent"}, bus.refresh_urgent, ur);
    check({tag, ".overflow"}, bus.refresh_overflow, ov);
  endtask

  initial begin
    logic [1:0] ec;
    logic       ev;

    // Phase A: clean init with cmd_ready tied high.
    bus.cmd_ready   = 1'b1;
    bus.refresh_ack = 1'b0;
    RESET           = 1'b1;
    step();
    step();
    check_reset("rst0");
    RESET = 1'b0;
    cyc   = 0;
    // PRE @16, REF @19 (+T_RP), REF @27 (+T_RFC), MODE @35 (+T_RFC), run @38.
    for (int c = 1; c <= 38; c++) begin
      step();
      ev = 1'b1;
      unique case (c)
        16:      ec = CMD_PRECHARGE_ALL;
        19, 27:  ec = CMD_AUTO_REFRESH;
        35:      ec = CMD_LOAD_MODE;
        default: begin ec = CMD_NOP; ev = 1'b0; end
      endcase
      check_cmd("initA", ev, ec);
      check("initA.init_done", bus.init_done, (c >= 38) ? 1 : 0);
    end
    check("mode_word", bus.mode_word, 12'h020);
    check_ref("run38", 0, 0, 0, 0);

    // No acks: one tick every 10 cycles from cycle 48.
    run_to(47);  check_ref("run47", 0, 0, 0, 0);
    run_to(48);  check_ref("tick1", 1, 1, 0, 0);
    run_to(77);  check_ref("run77", 3, 1, 0, 0);
    run_to(78);  check_ref("tick4", 4, 1, 1, 0);
    run_to(108); check_ref("tick7", 7, 1, 1, 0);
    run_to(117); check_ref("run117", 7, 1, 1, 0);
    run_to(118); check_ref("tick8", 7, 1, 1, 1);

    // Four acks between ticks: 7 -> 3.
    bus.refresh_ack = 1'b1;
    run_to(122); check_ref("ack4", 3, 1, 0, 1);
    bus.refresh_ack = 1'b0;
    run_to(127); check_ref("run127", 3, 1, 0, 1);
    // Ack coincides with the tick on edge 128.
    bus.refresh_ack = 1'b1;
    run_to(128); check_ref("tick_ack", 3, 1, 0, 1);
    run_to(131); check_ref("drain", 0, 0, 0, 1);
    run_to(132); check_ref("ack_at0", 0, 0, 0, 1);
    bus.refresh_ack = 1'b0;

    // Phase B: reset mid-run, then backpressure on PRECHARGE ALL.
    RESET = 1'b1;
    step();
    check_reset("rst1");
    RESET         = 1'b0;
    cyc           = 0;
    bus.cmd_ready = 1'b0;
    // PRE held 16..21, handshake on edge 22, REF @24, REF @32.
    for (int c = 1; c <= 35; c++) begin
      step();
      ev = 1'b1;
      if (c >= 16 && c <= 21)      ec = CMD_PRECHARGE_ALL;
      else if (c == 24 || c == 32) ec = CMD_AUTO_REFRESH;
      else begin ec = CMD_NOP; ev = 1'b0; end
      check_cmd("initB", ev, ec);
      check("initB.init_done", bus.init_done, 0);
      if (c == 21) bus.cmd_ready = 1'b1;
    end

    // Reset during the second T_RFC wait.
    RESET = 1'b1;
    step();
    check_reset("rst2");

    // Phase C: the full power-up wait repeats.
    RESET = 1'b0;
    cyc   = 0;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 16) check_cmd("initC", 1'b1, CMD_PRECHARGE_ALL);
      else         check_cmd("initC", 1'b0, CMD_NOP);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
